instr_enc_loader: RTL and testbench
===================================

# instr_enc_loader

- Encodes a stream of symbolic instruction commands into the 16-bit instruction format consumed by the instruction decoder, and writes them sequentially into instruction memory.
- Sits between the host/test port and the imem write port.
- Gates CPU execution: `cpu_run` asserts only after a complete program has been loaded and terminated by HALT.

## Interface
Parameters:
- AW, 8, imem address width; program capacity 2^AW words

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse; begins a load session
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a clock edge
- cmd_kind  in  3  0 NOP, 1 ALU, 2 HALT, 3 LL, 4 LH, 5–7 illegal
- cmd_wadr  in  2  destination register (ALU, LL, LH)
- cmd_aradr  in  2  source A (ALU)
- cmd_bradr  in  2  source B (ALU)
- cmd_op  in  3  ALU operation (ALU)
- cmd_imm  in  8  immediate byte (LL, LH)
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  16  encoded instruction
- prog_len  out  AW+1  number of words written this session
- cpu_run  out  1  high in DONE; releases the CPU
- err  out  1  sticky; illegal cmd_kind seen this session
- ovf  out  1  sticky; capacity exhausted, HALT forced

## Operation
Encoding (unused fields are zero):
- NOP: 16'h0000
- HALT: 16'h0001
- ALU: [15:13]=000, [11:10]=wadr, [9:8]=aradr, [6:4]=op, [2]=1, [1:0]=bradr
- LL: [15:13]=010, [12]=0, [11:10]=wadr, [7:0]=imm
- LH: [15:13]=010, [12]=1, [11:10]=wadr, [7:0]=imm

FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: cmd_ready=0. On start → LOAD; addr, prog_len, err and ovf are cleared.
- LOAD: cmd_ready=1.
  - Legal accept: the encoded word and the current addr are registered → WRITE.
  - Illegal accept: the command is consumed, err is set, no write occurs, FSM stays in LOAD.
- WRITE: cmd_ready=0; imem_we=1 for exactly one cycle; prog_len increments.
  - If the written word is HALT → DONE.
  - Otherwise addr increments → LOAD.
- Last slot (addr = 2^AW−1):
  - A legal non-HALT command is replaced by 16'h0001 and ovf is set. It is still written and still leads to DONE.
  - An illegal command at the last slot behaves as any illegal command (err set, no write).
- DONE: cpu_run=1, cmd_ready=0. On start → LOAD (reload): cpu_run drops the next cycle, counters and flags are cleared.
- start in LOAD or WRITE is ignored.
- Reset at any time → IDLE. Reset does not alter imem contents.

Reset values: cmd_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, prog_len=0, cpu_run=0, err=0, ovf=0.

## Timing
- All outputs are registered.
- Accept at edge N → imem_we high during cycle N+1, with the addr and data registered at edge N. Data/address are stable for the whole strobe cycle.
- cmd_ready is low in the cycle after an accept, so maximum throughput is one command per 2 cycles.
- HALT accepted at edge N → written during cycle N+1 → cpu_run=1 from edge N+2.
- Illegal accept at edge N → err=1 from edge N+1; cmd_ready stays high.
- cmd_* fields are sampled only on an accept edge.
- start and cmd_valid in the same IDLE cycle: only start acts; no command is accepted.

## Test plan
- Reset, start, then stream ALU(w1,a2,op3,b3), LL(w2,A5), LH(w3,12), NOP, HALT → writes 0637@0, 48A5@1, 5C12@2, 0000@3, 0001@4; prog_len=5; cpu_run=1 two cycles after the HALT accept.
- cmd_valid held high continuously → cmd_ready toggles 1,0,1,0; one imem_we per accept; no command is lost or duplicated.
- cmd_kind=6 between two ALU commands → err=1, no write, addresses remain contiguous, session completes normally.
- AW=2, four ALU commands → addrs 0–2 hold ALU words; addr 3 holds 0001; ovf=1; DONE.
- In DONE, pulse start → cpu_run=0, prog_len=0, err/ovf cleared; a new load begins at addr 0.
- rst_n low during WRITE → next cycle in IDLE, all outputs at reset values, no further imem_we.

Source files
------------

// File: rtl/instr_enc_loader.sv
// rtl/instr_enc_loader.sv - encodes symbolic instruction commands and loads them into imem
// Gates cpu_run until a HALT-terminated program has been written.
module instr_enc_loader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_kind,
  input  logic [1:0]    cmd_wadr,
  input  logic [1:0]    cmd_aradr,
  input  logic [1:0]    cmd_bradr,
  input  logic [2:0]    cmd_op,
  input  logic [7:0]    cmd_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [15:0]   imem_wdata,
  output logic [AW:0]   prog_len,
  output logic          cpu_run,
  output logic          err,
  output logic          ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] K_NOP  = 3'd0;
  localparam logic [2:0] K_ALU  = 3'd1;
  localparam logic [2:0] K_HALT = 3'd2;
  localparam logic [2:0] K_LL   = 3'd3;
  localparam logic [2:0] K_LH   = 3'd4;

  localparam logic [15:0] HALT_WORD = 16'h0001;

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic          r_cmd_ready;
  logic          r_imem_we;
  logic [AW-1:0] r_imem_addr;
  logic [15:0]   r_imem_wdata;
  logic [AW:0]   r_prog_len;
  logic          r_cpu_run;
  logic          r_err;
  logic          r_ovf;

  logic          w_legal;
  logic          w_last;
  logic          w_force_halt;
  logic [15:0]   w_enc;
  logic [15:0]   w_word;

  always_comb begin
    w_legal      = (cmd_kind <= K_LH);
    w_last       = &r_addr;
    w_force_halt = w_last && (cmd_kind != K_HALT);
    case (cmd_kind)
      K_NOP:   w_enc = 16'h0000;
      K_ALU:   w_enc = {3'b000, 1'b0, cmd_wadr, cmd_aradr, 1'b0, cmd_op, 1'b0, 1'b1, cmd_bradr};
      K_HALT:  w_enc = HALT_WORD;
      K_LL:    w_enc = {3'b010, 1'b0, cmd_wadr, 2'b00, cmd_imm};
      K_LH:    w_enc = {3'b010, 1'b1, cmd_wadr, 2'b00, cmd_imm};
      default: w_enc = 16'h0000;
    endcase
    // The final slot must always terminate the program.
    w_word = w_force_halt ? HALT_WORD : w_enc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_cmd_ready  <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 16'h0000;
      r_prog_len   <= '0;
      r_cpu_run    <= 1'b0;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      r_cpu_run <= (r_state == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_cmd_ready <= 1'b1;
            r_addr      <= '0;
            r_prog_len  <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (cmd_valid) begin
            if (w_legal) begin
              r_state      <= S_WRITE;
              r_cmd_ready  <= 1'b0;
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_addr;
              r_imem_wdata <= w_word;
              if (w_force_halt) r_ovf <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_prog_len <= r_prog_len + 1'b1;
          if (r_imem_wdata == HALT_WORD) begin
            r_state <= S_DONE;
          end else begin
            r_state     <= S_LOAD;
            r_cmd_ready <= 1'b1;
            r_addr      <= r_addr + 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign prog_len   = r_prog_len;
  assign cpu_run    = r_cpu_run;
  assign err        = r_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_instr_enc_loader.sv
// tb/tb_instr_enc_loader.sv - directed self-checking bench for instr_enc_loader
// A second instance with AW=2 exercises the capacity-exhausted path.
module tb_instr_enc_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_kind = '0;
  logic [1:0]  cmd_wadr = '0, cmd_aradr = '0, cmd_bradr = '0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_imm = '0;

  logic        cmd_ready, imem_we, cpu_run, err, ovf;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0]  prog_len;

  logic        cmd_ready2, imem_we2, cpu_run2, err2, ovf2;
  logic [1:0]  imem_addr2;
  logic [15:0] imem_wdata2;
  logic [2:0]  prog_len2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wd[$];
  logic [7:0]  wa[$];
  logic [15:0] wd2[$];
  logic [1:0]  wa2[$];

  instr_enc_loader #(.AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_wadr(cmd_wadr), .cmd_aradr(cmd_aradr), .cmd_bradr(cmd_bradr),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .prog_len(prog_len), .cpu_run(cpu_run), .err(err), .ovf(ovf)
  );

  instr_enc_loader #(.AW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_kind(cmd_kind), .cmd_wadr(cmd_wadr), .cmd_aradr(cmd_aradr), .cmd_bradr(cmd_bradr),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .prog_len(prog_len2), .cpu_run(cpu_run2), .err(err2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  // Stand-in for the instruction memory: every strobed write is logged.
  always @(posedge clk) begin
    if (imem_we) begin
      wd.push_back(imem_wdata);
      wa.push_back(imem_addr);
    end
    if (imem_we2) begin
      wd2.push_back(imem_wdata2);
      wa2.push_back(imem_addr2);
    end
  end

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input bit which, input logic [2:0] k, input logic [1:0] w,
                      input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                      input logic [7:0] imm);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    cmd_kind = k; cmd_wadr = w; cmd_aradr = a; cmd_bradr = b; cmd_op = op; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!acc && n < 16) begin
      acc = which ? cmd_ready2 : cmd_ready;
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_accept: kind %0d not accepted, required accept within 16 cycles", k);
    end
  endtask

  task automatic wait_run(input bit which);
    int n;
    n = 0;
    while (!(which ? cpu_run2 : cpu_run) && n < 8) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!(which ? cpu_run2 : cpu_run)) begin
      n_bad++;
      $display("FAIL cpu_run_timeout: cpu_run=0, required 1 within 8 cycles");
    end
  endtask

  task automatic test_reset;
    cmd_valid = 1'b1;
    cmd_kind = 3'd1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, imem_we, cpu_run, err, ovf} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 00000", {cmd_ready, imem_we, cpu_run, err, ovf});
    end
    n_cmp++;
    if ({imem_addr, imem_wdata, prog_len} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset_regs: addr %h data %h len %h, required all 0", imem_addr, imem_wdata, prog_len);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0 || wd.size() != 0) begin
      n_bad++;
      $display("FAIL idle_ignores_cmd: ready %b writes %0d, required 0 and 0", cmd_ready, wd.size());
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || wd.size() != 0) begin
      n_bad++;
      $display("FAIL start_with_valid: ready %b writes %0d, required 1 and 0", cmd_ready, wd.size());
    end
  endtask

  task automatic test_program;
    logic [15:0] exp_d [5] = '{16'h0637, 16'h48A5, 16'h5C12, 16'h0000, 16'h0001};
    wd.delete(); wa.delete();
    pulse_start(0);
    send(0, 3'd1, 2'd1, 2'd2, 2'd3, 3'd3, 8'h00);
    send(0, 3'd3, 2'd2, 2'd0, 2'd0, 3'd0, 8'hA5);
    send(0, 3'd4, 2'd3, 2'd0, 2'd0, 3'd0, 8'h12);
    send(0, 3'd0, 2'd0, 2'd0, 2'd0, 3'd0, 8'h00);
    send(0, 3'd2, 2'd0, 2'd0, 2'd0, 3'd0, 8'h00);
    n_cmp++;
    if (cpu_run !== 1'b0 || imem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_write_cycle: run %b we %b, required 0 and 1", cpu_run, imem_we);
    end
    @(negedge clk);
    n_cmp++;
    if (cpu_run !== 1'b0) begin
      n_bad++;
      $display("FAIL run_early: cpu_run=%b one cycle after write, required 0", cpu_run);
    end
    @(negedge clk);
    n_cmp++;
    if (cpu_run !== 1'b1 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL run_done: run %b ready %b, required 1 and 0", cpu_run, cmd_ready);
    end
    n_cmp++;
    if (wd.size() != 5 || prog_len !== 9'd5) begin
      n_bad++;
      $display("FAIL prog_count: writes %0d len %0d, required 5 and 5", wd.size(), prog_len);
    end
    for (int i = 0; i < 5 && i < wd.size(); i++) begin
      n_cmp++;
      if (wd[i] !== exp_d[i] || wa[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL prog_word[%0d]: got %h@%0d, required %h@%0d", i, wd[i], wa[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  k  [4] = '{3'd1, 3'd1, 3'd1, 3'd2};
    logic [1:0]  w  [4] = '{2'd0, 2'd3, 2'd2, 2'd0};
    logic [1:0]  a  [4] = '{2'd1, 2'd0, 2'd3, 2'd0};
    logic [1:0]  b  [4] = '{2'd3, 2'd1, 2'd0, 2'd0};
    logic [2:0]  op [4] = '{3'd2, 3'd7, 3'd5, 3'd0};
    logic [15:0] exp_d [4] = '{16'h0127, 16'h0C75, 16'h0B54, 16'h0001};
    int idx;
    logic acc;
    wd.delete(); wa.delete();
    pulse_start(0);
    idx = 0;
    cmd_kind = k[0]; cmd_wadr = w[0]; cmd_aradr = a[0]; cmd_bradr = b[0]; cmd_op = op[0];
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cmd_ready !== ((i % 2) == 0)) begin
        n_bad++;
        $display("FAIL b2b_ready[%0d]: got %b, required %b", i, cmd_ready, (i % 2) == 0);
      end
      acc = cmd_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 4) begin
          cmd_kind = k[idx]; cmd_wadr = w[idx]; cmd_aradr = a[idx]; cmd_bradr = b[idx]; cmd_op = op[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    wait_run(0);
    n_cmp++;
    if (wd.size() != 4 || prog_len !== 9'd4) begin
      n_bad++;
      $display("FAIL b2b_count: writes %0d len %0d, required 4 and 4", wd.size(), prog_len);
    end
    for (int i = 0; i < 4 && i < wd.size(); i++) begin
      n_cmp++;
      if (wd[i] !== exp_d[i] || wa[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL b2b_word[%0d]: got %h@%0d, required %h@%0d", i, wd[i], wa[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_illegal;
    logic [15:0] exp_d [3] = '{16'h0515, 16'h0A26, 16'h0001};
    wd.delete(); wa.delete();
    pulse_start(0);
    send(0, 3'd1, 2'd1, 2'd1, 2'd1, 3'd1, 8'h00);
    send(0, 3'd6, 2'd3, 2'd3, 2'd3, 3'd7, 8'hFF);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_ready: got %b, required 1", cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || wd.size() != 1) begin
      n_bad++;
      $display("FAIL illegal_err: err %b writes %0d, required 1 and 1", err, wd.size());
    end
    send(0, 3'd1, 2'd2, 2'd2, 2'd2, 3'd2, 8'h00);
    send(0, 3'd2, 2'd0, 2'd0, 2'd0, 3'd0, 8'h00);
    wait_run(0);
    n_cmp++;
    if (wd.size() != 3 || prog_len !== 9'd3 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_session: writes %0d len %0d err %b, required 3, 3, 1", wd.size(), prog_len, err);
    end
    for (int i = 0; i < 3 && i < wd.size(); i++) begin
      n_cmp++;
      if (wd[i] !== exp_d[i] || wa[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL illegal_word[%0d]: got %h@%0d, required %h@%0d", i, wd[i], wa[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_reload;
    wd.delete(); wa.delete();
    pulse_start(0);
    @(negedge clk);
    n_cmp++;
    if ({cpu_run, err, ovf, cmd_ready} !== 4'b0001 || prog_len !== 9'd0) begin
      n_bad++;
      $display("FAIL reload_clear: run/err/ovf/ready %b len %0d, required 0001 and 0",
               {cpu_run, err, ovf, cmd_ready}, prog_len);
    end
    send(0, 3'd3, 2'd1, 2'd0, 2'd0, 3'd0, 8'h3C);
    send(0, 3'd2, 2'd0, 2'd0, 2'd0, 3'd0, 8'h00);
    wait_run(0);
    n_cmp++;
    if (wd.size() != 2 || prog_len !== 9'd2) begin
      n_bad++;
      $display("FAIL reload_count: writes %0d len %0d, required 2 and 2", wd.size(), prog_len);
    end else begin
      n_cmp++;
      if (wd[0] !== 16'h443C || wa[0] !== 8'd0 || wd[1] !== 16'h0001 || wa[1] !== 8'd1) begin
        n_bad++;
        $display("FAIL reload_words: got %h@%0d %h@%0d, required 443c@0 0001@1", wd[0], wa[0], wd[1], wa[1]);
      end
    end
  endtask

  task automatic test_reset_in_write;
    int cnt;
    pulse_start(0);
    send(0, 3'd1, 2'd1, 2'd2, 2'd3, 3'd3, 8'h00);
    n_cmp++;
    if (imem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL rw_in_write: imem_we=%b, required 1", imem_we);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, imem_we, cpu_run, err, ovf} !== 5'b0 || {imem_addr, imem_wdata, prog_len} !== 33'h0) begin
      n_bad++;
      $display("FAIL rw_reset_vals: flags %b addr %h data %h len %h, required all 0",
               {cmd_ready, imem_we, cpu_run, err, ovf}, imem_addr, imem_wdata, prog_len);
    end
    cnt = wd.size();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wd.size() != cnt || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_idle: extra writes %0d ready %b, required 0 and 0", wd.size() - cnt, cmd_ready);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] exp_d [4] = '{16'h0637, 16'h0637, 16'h0637, 16'h0001};
    wd2.delete(); wa2.delete();
    pulse_start(1);
    for (int i = 0; i < 4; i++) send(1, 3'd1, 2'd1, 2'd2, 2'd3, 3'd3, 8'h00);
    wait_run(1);
    n_cmp++;
    if (ovf2 !== 1'b1 || err2 !== 1'b0 || prog_len2 !== 3'd4 || cmd_ready2 !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_flags: ovf %b err %b len %0d ready %b, required 1, 0, 4, 0",
               ovf2, err2, prog_len2, cmd_ready2);
    end
    n_cmp++;
    if (wd2.size() != 4) begin
      n_bad++;
      $display("FAIL ovf_count: writes %0d, required 4", wd2.size());
    end
    for (int i = 0; i < 4 && i < wd2.size(); i++) begin
      n_cmp++;
      if (wd2[i] !== exp_d[i] || wa2[i] !== 2'(i)) begin
        n_bad++;
        $display("FAIL ovf_word[%0d]: got %h@%0d, required %h@%0d", i, wd2[i], wa2[i], exp_d[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_back_to_back();
    test_illegal();
    test_reload();
    test_reset_in_write();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
